// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default 640x480@60 timing constants and derived totals
// Revision       : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE       = 640;
    localparam int unsigned DEF_H_FRONT         = 16;
    localparam int unsigned DEF_H_SYNC          = 96;
    localparam int unsigned DEF_H_BACK          = 48;
    localparam int unsigned DEF_V_VISIBLE       = 480;
    localparam int unsigned DEF_V_FRONT         = 10;
    localparam int unsigned DEF_V_SYNC          = 2;
    localparam int unsigned DEF_V_BACK          = 33;
    localparam int unsigned DEF_PIPE_DELAY      = 2;
    localparam int unsigned DEF_FRAMES_PER_ANIM = 15;
    localparam int unsigned DEF_ANIM_COUNT      = 2;

    localparam int unsigned H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;

    // Counter width that never collapses to zero bits for single-value ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
// sync_delay : DEPTH-stage 1-bit shift register, stages reset to 1
// Revision   : 1.0
// ============================================================================
module sync_delay #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = clk_i ^ rst_ni;
            assign q_o      = d_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sr_q <= '1;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// vga_scan_gen : free-running VGA raster counters, delayed syncs, frame pulse
//                and animation-frame index
// Revision     : 1.0
// ============================================================================
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter  int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter  int unsigned H_FRONT         = DEF_H_FRONT,
    parameter  int unsigned H_SYNC          = DEF_H_SYNC,
    parameter  int unsigned H_BACK          = DEF_H_BACK,
    parameter  int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter  int unsigned V_FRONT         = DEF_V_FRONT,
    parameter  int unsigned V_SYNC          = DEF_V_SYNC,
    parameter  int unsigned V_BACK          = DEF_V_BACK,
    parameter  int unsigned PIPE_DELAY      = DEF_PIPE_DELAY,
    parameter  int unsigned FRAMES_PER_ANIM = DEF_FRAMES_PER_ANIM,
    parameter  int unsigned ANIM_COUNT      = DEF_ANIM_COUNT,
    localparam int unsigned SEL_W           = clog2_min1(ANIM_COUNT)
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             anim_pause,
    output logic [9:0]       DrawX,
    output logic [9:0]       DrawY,
    output logic             blank,
    output logic             hs,
    output logic             vs,
    output logic             frame_start,
    output logic [SEL_W-1:0] anim_sel
);

    localparam int unsigned FCNT_W = clog2_min1(FRAMES_PER_ANIM);

    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_ANIM - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(ANIM_COUNT - 1);

    logic [9:0]        hc_q, hc_d;
    logic [9:0]        vc_q, vc_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              fs_q, fs_d;
    logic              line_end;
    logic              frame_wrap;
    logic              raw_hs;
    logic              raw_vs;

    always_comb begin
        line_end   = (hc_q == H_LAST);
        frame_wrap = line_end && (vc_q == V_LAST);

        hc_d = line_end ? 10'd0 : hc_q + 10'd1;
        vc_d = vc_q;
        if (line_end) begin
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end

        fs_d   = frame_wrap;
        fcnt_d = fcnt_q;
        sel_d  = sel_q;
        // Animation state only moves on the frame edge, so anim_sel is stable per frame.
        if (frame_wrap && !anim_pause) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q   <= '0;
            vc_q   <= '0;
            fcnt_q <= '0;
            sel_q  <= '0;
            fs_q   <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            fcnt_q <= fcnt_d;
            sel_q  <= sel_d;
            fs_q   <= fs_d;
        end
    end

    assign raw_hs = !((hc_q >= H_SYNC_BEG) && (hc_q <= H_SYNC_END));
    assign raw_vs = !((vc_q >= V_SYNC_BEG) && (vc_q <= V_SYNC_END));

    // Syncs lag by the mapper RGB latency so they leave the chip with their pixel.
    sync_delay #(.DEPTH(PIPE_DELAY)) u_hs_dly (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .d_i    (raw_hs),
        .q_o    (hs)
    );

    sync_delay #(.DEPTH(PIPE_DELAY)) u_vs_dly (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .d_i    (raw_vs),
        .q_o    (vs)
    );

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign frame_start = fs_q;
    assign anim_sel    = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_scan_gen : default-timing instance for line-level vectors, small-timing
//                   instances for whole-frame, sync, animation and reset sequences
// Revision        : 1.0
// ============================================================================
module tb_vga_scan_gen;

    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;   // 25
    localparam int SVT = SVV + SVF + SVS + SVB;   // 15
    localparam int SFRAME = SHT * SVT;            // 375

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic anim_pause = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] d_x, d_y, s_x, s_y, z_x, z_y;
    logic       d_blank, d_hs, d_vs, d_fs, s_blank, s_hs, s_vs, s_fs, z_blank, z_hs, z_vs, z_fs;
    logic [0:0] d_sel, s_sel, z_sel;

    vga_scan_gen dut_def (
        .vga_clk(clk), .reset_n(reset_n), .anim_pause(anim_pause),
        .DrawX(d_x), .DrawY(d_y), .blank(d_blank), .hs(d_hs), .vs(d_vs),
        .frame_start(d_fs), .anim_sel(d_sel)
    );

    vga_scan_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .PIPE_DELAY(2), .FRAMES_PER_ANIM(3), .ANIM_COUNT(2)
    ) dut_sm (
        .vga_clk(clk), .reset_n(reset_n), .anim_pause(anim_pause),
        .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
        .frame_start(s_fs), .anim_sel(s_sel)
    );

    vga_scan_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .PIPE_DELAY(0)
    ) dut_p0 (
        .vga_clk(clk), .reset_n(reset_n), .anim_pause(anim_pause),
        .DrawX(z_x), .DrawY(z_y), .blank(z_blank), .hs(z_hs), .vs(z_vs),
        .frame_start(z_fs), .anim_sel(z_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model of the small instance
    int   mx, my, since, k, nedge, exp_fcnt, exp_sel;
    logic exp_fs;
    int   e_xy, e_blank, e_hs, e_vs, e_fs, e_sel, e_selchg, e_p0;
    int   blank_cnt, fs_cnt;
    int   sel_log [0:7];
    logic prev_hs, prev_vs, prev_sel;
    int   hs_run, vs_run, hs_fall_x, hs_len, vs_fall_x, vs_fall_y, vs_len;

    function automatic logic raw_h(input int x);
        return (x >= SHV + SHF && x <= SHV + SHF + SHS - 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic raw_v(input int y);
        return (y >= SVV + SVF && y <= SVV + SVF + SVS - 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; since = 0; k = 0;
        exp_fcnt = 0; exp_sel = 0; exp_fs = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_sel = 1'b0;
        hs_run = 0; vs_run = 0;
    endtask

    task automatic tick();
        logic p, r;
        int   lp;
        logic wrap, eh, ev;
        p = anim_pause;
        r = reset_n;
        @(posedge clk);
        #1;
        exp_fs = 1'b0;
        if (r) begin
            wrap = (mx == SHT - 1 && my == SVT - 1);
            if (mx == SHT - 1) begin
                mx = 0;
                my = (my == SVT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            since++;
            k++;
            if (wrap) begin
                exp_fs = 1'b1;
                nedge++;
                if (!p) begin
                    if (exp_fcnt == 2) begin
                        exp_fcnt = 0;
                        exp_sel  = (exp_sel + 1) % 2;
                    end else begin
                        exp_fcnt++;
                    end
                end
                if (nedge < 8) sel_log[nedge] = int'(s_sel);
            end
        end
        lp = (my * SHT + mx - 2 + SFRAME) % SFRAME;
        eh = (since < 2) ? 1'b1 : raw_h(lp % SHT);
        ev = (since < 2) ? 1'b1 : raw_v(lp / SHT);
        if (s_x !== 10'(mx) || s_y !== 10'(my)) e_xy++;
        if (s_blank !== (mx < SHV && my < SVV)) e_blank++;
        if (s_hs !== eh) e_hs++;
        if (s_vs !== ev) e_vs++;
        if (s_fs !== exp_fs) e_fs++;
        if (s_sel !== 1'(exp_sel)) e_sel++;
        if (s_sel !== prev_sel && !(s_x == 10'd0 && s_y == 10'd0)) e_selchg++;
        if (z_x !== 10'(mx) || z_hs !== raw_h(mx) || z_vs !== raw_v(my)) e_p0++;
        if (nedge == 1) begin
            if (s_blank === 1'b1) blank_cnt++;
            if (s_fs === 1'b1) fs_cnt++;
        end
        if (prev_hs === 1'b1 && s_hs === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(s_x);
        if (s_hs === 1'b0) hs_run++;
        else begin
            if (prev_hs === 1'b0 && hs_len < 0) hs_len = hs_run;
            hs_run = 0;
        end
        if (prev_vs === 1'b1 && s_vs === 1'b0 && vs_fall_x < 0) begin
            vs_fall_x = int'(s_x);
            vs_fall_y = int'(s_y);
        end
        if (s_vs === 1'b0) vs_run++;
        else begin
            if (prev_vs === 1'b0 && vs_len < 0) vs_len = vs_run;
            vs_run = 0;
        end
        prev_hs  = s_hs;
        prev_vs  = s_vs;
        prev_sel = s_sel;
    endtask

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic b;
        logic hs;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{k: 1,    x: 1,   y: 0, b: 1'b1, hs: 1'b1};
        tbl[1]  = '{k: 639,  x: 639, y: 0, b: 1'b1, hs: 1'b1};
        tbl[2]  = '{k: 640,  x: 640, y: 0, b: 1'b0, hs: 1'b1};
        tbl[3]  = '{k: 657,  x: 657, y: 0, b: 1'b0, hs: 1'b1};
        tbl[4]  = '{k: 658,  x: 658, y: 0, b: 1'b0, hs: 1'b0};
        tbl[5]  = '{k: 753,  x: 753, y: 0, b: 1'b0, hs: 1'b0};
        tbl[6]  = '{k: 754,  x: 754, y: 0, b: 1'b0, hs: 1'b1};
        tbl[7]  = '{k: 799,  x: 799, y: 0, b: 1'b0, hs: 1'b1};
        tbl[8]  = '{k: 800,  x: 0,   y: 1, b: 1'b1, hs: 1'b1};
        tbl[9]  = '{k: 801,  x: 1,   y: 1, b: 1'b1, hs: 1'b1};
        tbl[10] = '{k: 1458, x: 658, y: 1, b: 1'b0, hs: 1'b0};
        tbl[11] = '{k: 1554, x: 754, y: 1, b: 1'b0, hs: 1'b1};

        model_reset();
        nedge = 0;
        e_xy = 0; e_blank = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_sel = 0; e_selchg = 0; e_p0 = 0;
        blank_cnt = 0; fs_cnt = 0;
        hs_fall_x = -1; hs_len = -1; vs_fall_x = -1; vs_fall_y = -1; vs_len = -1;
        for (int i = 0; i < 8; i++) sel_log[i] = -1;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        check("rst_def_x",     32'(d_x), 0);
        check("rst_def_y",     32'(d_y), 0);
        check("rst_def_blank", 32'(d_blank), 1);
        check("rst_def_hs",    32'(d_hs), 1);
        check("rst_def_vs",    32'(d_vs), 1);
        check("rst_def_fs",    32'(d_fs), 0);
        check("rst_def_sel",   32'(d_sel), 0);
        check("rst_sm_x",      32'(s_x), 0);
        check("rst_sm_hs",     32'(s_hs), 1);
        check("rst_sm_sel",    32'(s_sel), 0);

        reset_n = 1'b1;
        tick();
        check("release_sm_x", 32'(s_x), 1);

        // Default-timing line vectors, indexed by edges since reset release
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) tick();
            check($sformatf("vec%0d_x", i),     32'(d_x), 32'(tbl[i].x));
            check($sformatf("vec%0d_y", i),     32'(d_y), 32'(tbl[i].y));
            check($sformatf("vec%0d_blank", i), 32'(d_blank), 32'(tbl[i].b));
            check($sformatf("vec%0d_hs", i),    32'(d_hs), 32'(tbl[i].hs));
            check($sformatf("vec%0d_vs", i),    32'(d_vs), 1);
        end

        // Animation sequence at successive frame starts: 0,0,0,1,1,1,0
        while (nedge < 7) tick();
        check("anim_fs1", 32'(sel_log[1]), 0);
        check("anim_fs2", 32'(sel_log[2]), 0);
        check("anim_fs3", 32'(sel_log[3]), 1);
        check("anim_fs4", 32'(sel_log[4]), 1);
        check("anim_fs5", 32'(sel_log[5]), 1);
        check("anim_fs6", 32'(sel_log[6]), 0);
        check("frame_visible_count", 32'(blank_cnt), 32'(SHV * SVV));
        check("frame_start_count",   32'(fs_cnt), 1);
        check("hs_fall_x",  32'(hs_fall_x), 32'(SHV + SHF + 2));
        check("hs_low_len", 32'(hs_len), 32'(SHS));
        check("vs_fall_x",  32'(vs_fall_x), 2);
        check("vs_fall_y",  32'(vs_fall_y), 32'(SVV + SVF));
        check("vs_low_len", 32'(vs_len), 32'(SVS * SHT));

        // Pause over four frame edges, engaged and released mid-frame
        while (mx != 5) tick();
        anim_pause = 1'b1;
        while (nedge < 11) tick();
        check("pause_sel_hold", 32'(s_sel), 0);
        while (mx != 5) tick();
        anim_pause = 1'b0;
        while (nedge < 12) tick();
        check("unpause_edge1_sel", 32'(s_sel), 0);
        while (nedge < 13) tick();
        check("unpause_edge2_sel", 32'(s_sel), 1);

        // Asynchronous reset while hs/vs are low and anim_sel is 1
        for (int n = 0; n < 2 * SFRAME && !(mx == SHV + SHF + 3 && my == SVV + SVF); n++) tick();
        check("pre_rst_x",     32'(s_x), 32'(SHV + SHF + 3));
        check("pre_rst_hs",    32'(s_hs), 0);
        check("pre_rst_vs",    32'(s_vs), 0);
        check("pre_rst_blank", 32'(s_blank), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_x",     32'(s_x), 0);
        check("mid_rst_y",     32'(s_y), 0);
        check("mid_rst_blank", 32'(s_blank), 1);
        check("mid_rst_hs",    32'(s_hs), 1);
        check("mid_rst_vs",    32'(s_vs), 1);
        check("mid_rst_fs",    32'(s_fs), 0);
        check("mid_rst_sel",   32'(s_sel), 0);
        check("mid_rst_def_x", 32'(d_x), 0);
        check("mid_rst_def_y", 32'(d_y), 0);
        model_reset();
        @(posedge clk);
        #1;
        check("held_rst_x", 32'(s_x), 0);
        reset_n = 1'b1;
        tick();
        check("rerelease_x",   32'(s_x), 1);
        check("rerelease_sel", 32'(s_sel), 0);
        repeat (SFRAME + 10) tick();

        check("cycle_counters", 32'(e_xy), 0);
        check("cycle_blank",    32'(e_blank), 0);
        check("cycle_hs",       32'(e_hs), 0);
        check("cycle_vs",       32'(e_vs), 0);
        check("cycle_fs",       32'(e_fs), 0);
        check("cycle_sel",      32'(e_sel), 0);
        check("sel_stable",     32'(e_selchg), 0);
        check("nodelay_sync",   32'(e_p0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
